// File: rtl/qsgmii_tx_pcs.sv
// qsgmii_tx_pcs -- four-lane QSGMII transmit PCS.
//
// Each sub-lane turns a GMII byte stream into 8b/10b pre-encode symbols:
// idle pairs, /S/ /T/ /R/ delimiters, /V/ error propagation and SGMII
// autoneg /C/ ordered sets. The GT encoder tracks running disparity; this
// block only requests a forced-negative symbol on the first idle after a
// frame. Output latency is one cycle; all outputs are registered.
//
// Ports:
//   tx_clk                       word clock (GT txusrclk2)
//   tx_rst                       synchronous, active-high reset
//   gmii_tx_en/er [LANES]        per-lane frame valid / error
//   gmii_txd      [8*LANES]      per-lane data byte, lane n at [8n+7:8n]
//   cfg_en        [LANES]        per-lane: send autoneg /C/ ordered sets
//   cfg_word      [16*LANES]     per-lane config word, lane n at [16n+15:16n]
//   tx_data       [8*LANES]      symbol bytes to the GT
//   tx_data_is_ctl[LANES]        K-character flag
//   tx_force_disparity_negative  force negative disparity on this symbol
//   tx_drop       [LANES]        pulse: input byte discarded (protocol violation)
module qsgmii_tx_pcs #(
    parameter int LANES = 4
) (
    input  logic                  tx_clk,
    input  logic                  tx_rst,
    input  logic [LANES-1:0]      gmii_tx_en,
    input  logic [LANES-1:0]      gmii_tx_er,
    input  logic [LANES*8-1:0]    gmii_txd,
    input  logic [LANES-1:0]      cfg_en,
    input  logic [LANES*16-1:0]   cfg_word,
    output logic [LANES*8-1:0]    tx_data,
    output logic [LANES-1:0]      tx_data_is_ctl,
    output logic [LANES-1:0]      tx_force_disparity_negative,
    output logic [LANES-1:0]      tx_drop
);
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_1 = 8'h3C;
    localparam logic [7:0] D16_2 = 8'h50;
    localparam logic [7:0] K27_7 = 8'hFB;  // /S/
    localparam logic [7:0] K29_7 = 8'hFD;  // /T/
    localparam logic [7:0] K23_7 = 8'hF7;  // /R/
    localparam logic [7:0] K30_7 = 8'hFE;  // /V/
    localparam logic [7:0] D21_5 = 8'hB5;
    localparam logic [7:0] D2_2  = 8'h42;

    typedef enum logic [2:0] {IDLE_K, IDLE_D, DATA, EOP_R, EOP_R2, CFG} state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       is_ctl;
        logic       force_neg;
        logic       drop;
    } sym_t;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        // Lane 0 carries K28.1 in place of K28.5 so the receiver can find lane 0.
        localparam logic [7:0] K_IDLE = (g == 0) ? K28_1 : K28_5;

        logic        en, er, ce;
        logic [7:0]  txd;
        logic [15:0] cw;

        assign en  = gmii_tx_en[g];
        assign er  = gmii_tx_er[g];
        assign ce  = cfg_en[g];
        assign txd = gmii_txd[8*g +: 8];
        assign cw  = cfg_word[16*g +: 16];

        state_t      st, st_nx;
        logic        par;              // position of the symbol being built: 0 = even
        logic        stop, stop_nx;    // cfg_en seen low during the current ordered set
        logic        eop_q, eop_nx;    // this IDLE_K directly follows a frame's /R/
        logic [2:0]  cnt, cnt_nx;      // index within the 8-symbol C1/C2 loop
        logic [15:0] cfg_q, cfg_nx;    // config word latched at each K28.5
        sym_t        o_q, o_nx;

        always_ff @(posedge tx_clk) begin
            if (tx_rst) begin
                st    <= IDLE_K;
                par   <= 1'b0;
                stop  <= 1'b0;
                eop_q <= 1'b0;
                cnt   <= 3'd0;
                cfg_q <= 16'd0;
                o_q   <= '{data: K_IDLE, is_ctl: 1'b1, force_neg: 1'b0, drop: 1'b0};
            end else begin
                st    <= st_nx;
                par   <= ~par;
                stop  <= stop_nx;
                eop_q <= eop_nx;
                cnt   <= cnt_nx;
                cfg_q <= cfg_nx;
                o_q   <= o_nx;
            end
        end

        always_comb begin
            st_nx   = st;
            stop_nx = stop;
            cnt_nx  = cnt;
            cfg_nx  = cfg_q;
            eop_nx  = (st == EOP_R && par) || (st == EOP_R2);
            case (st)
                IDLE_K: begin
                    // The K28.5 emitted here doubles as the first symbol of C1.
                    if (ce) begin
                        st_nx   = CFG;
                        cnt_nx  = 3'd1;
                        cfg_nx  = cw;
                        stop_nx = 1'b0;
                    end else if (en) begin
                        st_nx = DATA;
                    end else begin
                        st_nx = IDLE_D;
                    end
                end
                IDLE_D: st_nx = IDLE_K;
                DATA:   if (!en) st_nx = EOP_R;
                // A second /R/ is needed only to bring the next idle back to even.
                EOP_R:  st_nx = par ? IDLE_K : EOP_R2;
                EOP_R2: st_nx = IDLE_K;
                CFG: begin
                    cnt_nx = cnt + 3'd1;
                    if (!ce) stop_nx = 1'b1;
                    if (cnt[1:0] == 2'd0) cfg_nx = cw;
                    if (cnt[1:0] == 2'd3 && (stop || !ce)) st_nx = IDLE_K;
                end
                default: st_nx = IDLE_K;
            endcase
        end

        always_comb begin
            o_nx = '{data: K_IDLE, is_ctl: 1'b1, force_neg: 1'b0, drop: 1'b0};
            case (st)
                IDLE_K: begin
                    if (en && !ce) o_nx.data = K27_7;
                    else           o_nx.force_neg = eop_q;
                    o_nx.drop = en && ce;
                end
                IDLE_D: begin
                    o_nx.data   = D16_2;
                    o_nx.is_ctl = 1'b0;
                end
                DATA: begin
                    if (!en) begin
                        o_nx.data = K29_7;
                    end else if (er) begin
                        o_nx.data = K30_7;
                    end else begin
                        o_nx.data   = txd;
                        o_nx.is_ctl = 1'b0;
                    end
                end
                EOP_R, EOP_R2: begin
                    o_nx.data = K23_7;
                    o_nx.drop = en;
                end
                CFG: begin
                    o_nx.drop = en;
                    case (cnt[1:0])
                        2'd1: begin
                            o_nx.data   = cnt[2] ? D2_2 : D21_5;
                            o_nx.is_ctl = 1'b0;
                        end
                        2'd2: begin
                            o_nx.data   = cfg_q[7:0];
                            o_nx.is_ctl = 1'b0;
                        end
                        2'd3: begin
                            o_nx.data   = cfg_q[15:8];
                            o_nx.is_ctl = 1'b0;
                        end
                        default: begin end
                    endcase
                end
                default: begin end
            endcase
        end

        assign tx_data[8*g +: 8]              = o_q.data;
        assign tx_data_is_ctl[g]              = o_q.is_ctl;
        assign tx_force_disparity_negative[g] = o_q.force_neg;
        assign tx_drop[g]                     = o_q.drop;
    end
endmodule

// File: tb/tb_qsgmii_tx_pcs.sv
// Bench for qsgmii_tx_pcs: reset word, randomized frames on all lanes against
// a position-arithmetic frame model, mid-frame reset abort, and autoneg config.
module tb_qsgmii_tx_pcs;
    localparam int LANES = 4;
    localparam int N     = 600;

    logic        tx_clk = 1'b0;
    logic        tx_rst = 1'b1;
    logic [3:0]  gmii_tx_en = '0;
    logic [3:0]  gmii_tx_er = '0;
    logic [31:0] gmii_txd = '0;
    logic [3:0]  cfg_en = '0;
    logic [63:0] cfg_word = '0;
    logic [31:0] tx_data;
    logic [3:0]  tx_data_is_ctl;
    logic [3:0]  tx_force_disparity_negative;
    logic [3:0]  tx_drop;

    int nchk = 0;
    int npass = 0;
    int nfail = 0;

    // Per-lane stimulus and expected symbol stream, indexed by cycle after reset.
    bit         s_en [LANES][N];
    bit         s_er [LANES][N];
    logic [7:0] s_d  [LANES][N];
    logic [7:0] x_d  [LANES][N];
    bit         x_k  [LANES][N];
    bit         x_f  [LANES][N];

    // Expected lane 0 symbols for the config scenario.
    logic [7:0]  cfg0_d [19] = '{8'h3C, 8'hB5, 8'h01, 8'h40, 8'h3C, 8'h42, 8'h01, 8'h40,
                                 8'h3C, 8'hB5, 8'h01, 8'h40, 8'h3C, 8'h42, 8'h34, 8'h12,
                                 8'h3C, 8'h50, 8'h3C};
    logic [0:18] cfg0_k  = 19'b1000100010001000101;
    logic [0:18] cfg0_dr = 19'b1000001100000000000;
    logic [7:0]  cfg3_d [4] = '{8'hBC, 8'hB5, 8'hC3, 8'hA5};

    always #5 tx_clk = ~tx_clk;

    qsgmii_tx_pcs #(.LANES(LANES)) dut (
        .tx_clk                      (tx_clk),
        .tx_rst                      (tx_rst),
        .gmii_tx_en                  (gmii_tx_en),
        .gmii_tx_er                  (gmii_tx_er),
        .gmii_txd                    (gmii_txd),
        .cfg_en                      (cfg_en),
        .cfg_word                    (cfg_word),
        .tx_data                     (tx_data),
        .tx_data_is_ctl              (tx_data_is_ctl),
        .tx_force_disparity_negative (tx_force_disparity_negative),
        .tx_drop                     (tx_drop)
    );

    function automatic logic [7:0] k_idle(input int l);
        return (l == 0) ? 8'h3C : 8'hBC;
    endfunction

    task automatic step();
        @(posedge tx_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h (failure %0d)", tag, obs, exp, nfail);
        end
    endtask

    // Lane tuple {data, is_ctl, force_neg, drop}.
    task automatic chk_lane(input string tag, input int l, input logic [7:0] d,
                            input bit k, input bit f, input bit dr);
        chk(tag, {21'd0, tx_data[8*l +: 8], tx_data_is_ctl[l],
                  tx_force_disparity_negative[l], tx_drop[l]},
            {21'd0, d, k, f, dr});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int st, L, plen, p, q, r;
        bit first, e;
        logic [7:0] b;

        // ---- reset word ----
        tx_rst = 1'b1;
        step();
        step();
        chk("rst_data", tx_data, 32'hBCBCBC3C);
        chk("rst_ctl", {28'd0, tx_data_is_ctl}, 32'hF);
        chk("rst_force", {28'd0, tx_force_disparity_negative}, 32'h0);
        chk("rst_drop", {28'd0, tx_drop}, 32'h0);

        // ---- build random frame schedule and expected stream ----
        for (int l = 0; l < LANES; l++) begin
            for (int c = 0; c < N; c++) begin
                s_en[l][c] = 1'b0;
                s_er[l][c] = ($urandom_range(0, 3) == 0);  // tx_er without tx_en: ignored
                s_d[l][c]  = 8'($urandom);
                x_d[l][c]  = (c % 2 == 0) ? k_idle(l) : 8'h50;
                x_k[l][c]  = (c % 2 == 0);
                x_f[l][c]  = 1'b0;
            end
            st    = (l == 1) ? 5 : (l == 2) ? 4 : int'($urandom_range(2, 9));
            first = 1'b1;
            while (1) begin
                plen = (l == 2 && first) ? 64 : int'($urandom_range(8, 40));
                L    = 8 + plen;
                if (st + L + 8 > N) break;
                for (int i = 0; i < L; i++) begin
                    b = (i < 7) ? 8'h55 : (i == 7) ? 8'hD5 :
                        (l == 2 && first) ? 8'(i - 7) : 8'($urandom);
                    e = (l == 3 && first) ? (i == 12) : (i >= 8 && $urandom_range(0, 15) == 0);
                    s_en[l][st+i] = 1'b1;
                    s_d[l][st+i]  = b;
                    s_er[l][st+i] = e;
                end
                // /S/ lands on the first even position of the frame.
                p = st + (st % 2);
                for (int k = p; k < st + L; k++) begin
                    x_d[l][k] = (k == p) ? 8'hFB : s_er[l][k] ? 8'hFE : s_d[l][k];
                    x_k[l][k] = (k == p) || s_er[l][k];
                end
                x_d[l][st+L] = 8'hFD;
                x_k[l][st+L] = 1'b1;
                r = st + L + 1;
                x_d[l][r] = 8'hF7;
                x_k[l][r] = 1'b1;
                if (r % 2 == 0) begin
                    x_d[l][r+1] = 8'hF7;
                    x_k[l][r+1] = 1'b1;
                    q = r + 2;
                end else begin
                    q = r + 1;
                end
                x_f[l][q] = 1'b1;
                st    = q + int'($urandom_range(4, 16));
                first = 1'b0;
            end
        end

        // ---- run random frames ----
        for (int c = 0; c < N; c++) begin
            tx_rst   = 1'b0;
            cfg_en   = '0;
            cfg_word = {$urandom, $urandom};
            for (int l = 0; l < LANES; l++) begin
                gmii_tx_en[l]      = s_en[l][c];
                gmii_tx_er[l]      = s_er[l][c];
                gmii_txd[8*l +: 8] = s_d[l][c];
            end
            step();
            for (int l = 0; l < LANES; l++)
                chk_lane($sformatf("rand_l%0d_c%0d", l, c), l, x_d[l][c], x_k[l][c], x_f[l][c], 1'b0);
        end

        // ---- reset mid-frame ----
        gmii_tx_en = '0;
        gmii_tx_er = '0;
        tx_rst = 1'b1;
        step();
        chk("abort_pre_rst", tx_data, 32'hBCBCBC3C);
        tx_rst     = 1'b0;
        gmii_tx_en = 4'hF;
        gmii_txd   = 32'hAAAAAAAA;
        step();
        chk("abort_sop", tx_data, 32'hFBFBFBFB);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("abort_body", tx_data, 32'hAAAAAAAA);
        end
        tx_rst = 1'b1;
        step();
        chk("abort_rst_data", tx_data, 32'hBCBCBC3C);
        chk("abort_rst_ctl", {28'd0, tx_data_is_ctl}, 32'hF);
        tx_rst     = 1'b0;
        gmii_tx_en = '0;
        step();
        chk("abort_idle_k", tx_data, 32'hBCBCBC3C);
        chk("abort_idle_k_force", {28'd0, tx_force_disparity_negative}, 32'h0);
        step();
        chk("abort_idle_d", tx_data, 32'h50505050);
        gmii_tx_en = 4'hF;
        gmii_txd   = 32'h11111111;
        step();
        chk("restart_sop", tx_data, 32'hFBFBFBFB);
        gmii_txd = 32'h22222222;
        step();
        chk("restart_data", tx_data, 32'h22222222);
        gmii_tx_en = '0;
        step();
        chk("restart_t", tx_data, 32'hFDFDFDFD);
        step();
        chk("restart_r", tx_data, 32'hF7F7F7F7);
        step();
        chk("restart_idle", tx_data, 32'hBCBCBC3C);
        chk("restart_force", {28'd0, tx_force_disparity_negative}, 32'hF);
        step();
        chk("restart_idle_d", tx_data, 32'h50505050);
        chk("restart_force_off", {28'd0, tx_force_disparity_negative}, 32'h0);

        // ---- autoneg config on lanes 0 and 3 ----
        tx_rst = 1'b1;
        step();
        tx_rst = 1'b0;
        for (int c = 0; c < 19; c++) begin
            cfg_en[0]           = (c <= 12);
            cfg_en[3]           = (c <= 2);
            gmii_tx_en[0]       = (c == 0 || c == 6 || c == 7);
            cfg_word[15:0]      = (c < 9) ? 16'h4001 : 16'h1234;
            cfg_word[63:48]     = 16'hA5C3;
            step();
            chk_lane($sformatf("cfg_l0_c%0d", c), 0, cfg0_d[c], cfg0_k[c], 1'b0, cfg0_dr[c]);
            for (int l = 1; l < 3; l++)
                chk_lane($sformatf("cfg_l%0d_c%0d", l, c), l,
                         (c % 2 == 0) ? 8'hBC : 8'h50, (c % 2 == 0), 1'b0, 1'b0);
            if (c < 4)
                chk_lane($sformatf("cfg_l3_c%0d", c), 3, cfg3_d[c], (c == 0), 1'b0, 1'b0);
            else
                chk_lane($sformatf("cfg_l3_c%0d", c), 3,
                         (c % 2 == 0) ? 8'hBC : 8'h50, (c % 2 == 0), 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
